// File: rtl/ffn_bias_requant_unit_pkg.sv
// Shared fixed-point formats for the FFN datapath: Q6.10 activations and Q12.20 accumulators.
// Also holds the tile geometry and the types used by the bias/requant unit.
package ffn_bias_requant_unit_pkg;

    localparam int unsigned DATA_WIDTH    = 16;
    localparam int unsigned FRAC_BITS     = 10;
    localparam logic [DATA_WIDTH-1:0] Q_MAX = 16'h7FFF;
    localparam logic [DATA_WIDTH-1:0] Q_MIN = 16'h8000;

    localparam int unsigned ACC_WIDTH     = 32;
    localparam int unsigned ACC_FRAC_BITS = 20;
    localparam int unsigned SUM_WIDTH     = ACC_WIDTH + 1;

    localparam int unsigned COLS     = 64;
    localparam int unsigned ROWS     = 64;
    localparam int unsigned COL_BITS = 6;
    localparam int unsigned ROW_BITS = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Stage-1 payload: biased wide sum plus the end-of-row flag riding with it
    typedef struct packed {
        logic                 last;
        logic [SUM_WIDTH-1:0] sum;
    } stage1_t;

endpackage

// File: rtl/ffn_bias_requant_unit_if.sv
// Accumulator-in / Q6.10-out streaming bus of the bias/requant unit.
interface ffn_bias_requant_unit_if;
    import ffn_bias_requant_unit_pkg::*;

    logic                  acc_valid;
    logic                  acc_ready;
    logic [ACC_WIDTH-1:0]  acc_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  out_sat;

    modport master (
        output acc_valid, acc_in, out_ready,
        input  acc_ready, out_valid, out_data, out_last, out_sat
    );

    modport slave (
        input  acc_valid, acc_in, out_ready,
        output acc_ready, out_valid, out_data, out_last, out_sat
    );

endinterface

// File: rtl/ffn_bias_requant_unit_q_round_sat.sv
// Combinational round-half-up right shift followed by signed saturation to OUT_WIDTH.
// Generic so that layernorm and attention requant can reuse it.
module q_round_sat
    import ffn_bias_requant_unit_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = SUM_WIDTH,
    parameter int unsigned OUT_WIDTH = DATA_WIDTH,
    parameter int unsigned SHIFT     = ACC_FRAC_BITS - FRAC_BITS,
    parameter logic [OUT_WIDTH-1:0] SAT_MAX = Q_MAX,
    parameter logic [OUT_WIDTH-1:0] SAT_MIN = Q_MIN
) (
    input  logic [IN_WIDTH-1:0]  value,
    output logic [OUT_WIDTH-1:0] result,
    output logic                 sat
);

    // One guard bit so adding the half-LSB can never wrap
    localparam int unsigned EXT_W = IN_WIDTH + 1;
    localparam logic [EXT_W-1:0] HALF = EXT_W'(1) << (SHIFT - 1);

    logic [EXT_W-1:0] biased;
    logic [EXT_W-1:0] shifted;
    logic             pos_ovf;
    logic             neg_ovf;

    always_comb begin
        biased  = {value[IN_WIDTH-1], value} + HALF;
        shifted = EXT_W'($signed(biased) >>> SHIFT);
        pos_ovf = !shifted[EXT_W-1] && (|shifted[EXT_W-2:OUT_WIDTH-1]);
        neg_ovf = shifted[EXT_W-1] && !(&shifted[EXT_W-2:OUT_WIDTH-1]);
        sat     = pos_ovf || neg_ovf;
        if (pos_ovf) begin
            result = SAT_MAX;
        end else if (neg_ovf) begin
            result = SAT_MIN;
        end else begin
            result = shifted[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/ffn_bias_requant_unit.sv
// Adds a per-column Q6.10 bias to the Q12.20 accumulator stream of one tile and
// requantises to Q6.10 through a two-stage valid/ready pipeline framed by start/busy/done.
module ffn_bias_requant_unit
    import ffn_bias_requant_unit_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  bias_wr_en,
    input  logic [COL_BITS-1:0]   bias_wr_addr,
    input  logic [DATA_WIDTH-1:0] bias_wr_data,
    ffn_bias_requant_unit_if.slave stream,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned TILE_ELEMS = ROWS * COLS;
    localparam int unsigned CNT_W      = $clog2(TILE_ELEMS + 1);
    localparam int unsigned SHIFT      = ACC_FRAC_BITS - FRAC_BITS;

    state_t                state;
    logic [DATA_WIDTH-1:0] bias_mem [COLS];
    logic [CNT_W-1:0]      in_count;
    logic [CNT_W-1:0]      out_count;
    logic [COL_BITS-1:0]   in_col;

    stage1_t               s1;
    logic                  s1_valid;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_last_q;
    logic                  out_sat_q;

    logic                  en;
    logic                  acc_ready_c;
    logic                  take;
    logic                  fire;
    logic                  final_out;
    logic                  col_last;
    logic [DATA_WIDTH-1:0] bias_sel;
    logic [SUM_WIDTH-1:0]  acc_ext;
    logic [SUM_WIDTH-1:0]  bias_ext;
    logic [SUM_WIDTH-1:0]  sum;
    logic [DATA_WIDTH-1:0] rs_data;
    logic                  rs_sat;

    // Handshake, bias lookup and stage-1 sum
    always_comb begin
        en          = !out_valid_q || stream.out_ready;
        acc_ready_c = (state == ST_RUN) && en && (in_count < CNT_W'(TILE_ELEMS));
        take        = stream.acc_valid && acc_ready_c;
        fire        = out_valid_q && stream.out_ready;
        final_out   = fire && (out_count == CNT_W'(TILE_ELEMS - 1));
        col_last    = (in_col == COL_BITS'(COLS - 1));
        bias_sel    = bias_mem[in_col];
        acc_ext     = {stream.acc_in[ACC_WIDTH-1], stream.acc_in};
        bias_ext    = {{(SUM_WIDTH - DATA_WIDTH){bias_sel[DATA_WIDTH-1]}}, bias_sel} << SHIFT;
        sum         = acc_ext + bias_ext;
    end

    // Bias table is deliberately not reset; writes land only while idle
    always_ff @(posedge clk) begin
        if (bias_wr_en && (state == ST_IDLE)) begin
            bias_mem[bias_wr_addr] <= bias_wr_data;
        end
    end

    q_round_sat #(
        .IN_WIDTH  (SUM_WIDTH),
        .OUT_WIDTH (DATA_WIDTH),
        .SHIFT     (SHIFT),
        .SAT_MAX   (Q_MAX),
        .SAT_MIN   (Q_MIN)
    ) u_round_sat (
        .value  (s1.sum),
        .result (rs_data),
        .sat    (rs_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            in_count    <= '0;
            out_count   <= '0;
            in_col      <= '0;
            s1          <= '0;
            s1_valid    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sat_q   <= 1'b0;
        end else begin
            done <= 1'b0;

            if (take) begin
                in_count <= in_count + CNT_W'(1);
                in_col   <= col_last ? '0 : in_col + COL_BITS'(1);
            end
            if (fire) begin
                out_count <= out_count + CNT_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_RUN;
                        busy      <= 1'b1;
                        in_count  <= '0;
                        out_count <= '0;
                        in_col    <= '0;
                    end
                end
                ST_RUN: begin
                    if (final_out) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // Both stages advance together; a stall freezes every stage register
            if (en) begin
                s1_valid    <= take;
                s1.sum      <= sum;
                s1.last     <= col_last;
                out_valid_q <= s1_valid;
                out_data_q  <= rs_data;
                out_sat_q   <= rs_sat;
                out_last_q  <= s1.last;
            end
        end
    end

    assign stream.acc_ready = acc_ready_c;
    assign stream.out_valid = out_valid_q;
    assign stream.out_data  = out_data_q;
    assign stream.out_last  = out_last_q;
    assign stream.out_sat   = out_sat_q;

endmodule

// File: tb/tb_ffn_bias_requant_unit.sv
// Scoreboard bench for ffn_bias_requant_unit: directed vectors, a full backpressured tile,
// control corner cases and a mid-tile reset.
module tb_ffn_bias_requant_unit;
    import ffn_bias_requant_unit_pkg::*;

    typedef struct packed {
        logic [15:0] d;
        logic        s;
        logic        l;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        bias_wr_en;
    logic [5:0]  bias_wr_addr;
    logic [15:0] bias_wr_data;
    logic        busy;
    logic        done;

    ffn_bias_requant_unit_if bus();

    ffn_bias_requant_unit dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bias_wr_en   (bias_wr_en),
        .bias_wr_addr (bias_wr_addr),
        .bias_wr_data (bias_wr_data),
        .stream       (bus),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    exp_t        exp_q[$];
    string       name_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          acc_cnt = 0;
    int          done_cnt = 0;
    int          done_acc = 0;
    int          ready_mode = 0;
    logic [15:0] bias_model [64];
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = 16'h0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [31:0] acc, input logic [15:0] b, input logic last);
        longint s;
        longint r;
        exp_t   e;
        s = longint'($signed(acc)) + longint'($signed(b)) * 1024;
        r = (s + 512) >>> 10;
        if (r > 32767)       e = '{d: 16'h7FFF, s: 1'b1, l: last};
        else if (r < -32768) e = '{d: 16'h8000, s: 1'b1, l: last};
        else                 e = '{d: 16'(r), s: 1'b0, l: last};
        return e;
    endfunction

    // Downstream ready: 0 = always ready, 1 = random ~50%, 2 = held off
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = 1'b0;
        endcase
    end

    // Monitor: pops the scoreboard on every accepted output and checks stall stability
    always @(negedge clk) begin
        exp_t  e;
        string nm;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold", {47'h0, bus.out_valid, bus.out_data}, {47'h0, 1'b1, prev_data});
            end
            if (bus.out_valid && bus.out_ready) begin
                acc_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", {46'h0, bus.out_data, bus.out_sat, bus.out_last}, 64'h0);
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    chk(nm, {46'h0, bus.out_data, bus.out_sat, bus.out_last}, {46'h0, e});
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            if (done) begin
                done_cnt++;
                done_acc = acc_cnt;
            end
        end
    end

    task automatic send(input logic [31:0] acc, input exp_t e, input string nm);
        logic got;
        got = 1'b0;
        bus.acc_valid = 1'b1;
        bus.acc_in    = acc;
        for (int k = 0; k < 5000 && !got; k++) begin
            @(negedge clk);
            if (bus.acc_ready) got = 1'b1;
        end
        if (!got) begin
            chk("acc_ready_timeout", 64'd0, 64'd1);
        end else begin
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
        @(posedge clk);
        #1;
        bus.acc_valid = 1'b0;
    endtask

    task automatic write_bias(input int col, input logic [15:0] val, input logic with_start);
        bias_wr_en   = 1'b1;
        bias_wr_addr = 6'(col);
        bias_wr_data = val;
        start        = with_start;
        @(posedge clk);
        #1;
        bias_wr_en = 1'b0;
        start      = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int a0);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 30000 && !seen; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && done_cnt > d0) seen = 1'b1;
        end
        chk("done_seen", {63'h0, seen}, 64'd1);
        repeat (5) @(negedge clk);
        chk("done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("done_after_accepts", 64'(done_acc - a0), 64'd4096);
        chk("busy_after_done", {63'h0, busy}, 64'd0);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk(nm, {40'h0, bus.out_valid, bus.out_data, bus.out_sat, bus.out_last, busy, done, bus.acc_ready},
            64'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] acc;
        int          d0;
        int          a0;
        int          col;

        rst           = 1'b1;
        start         = 1'b0;
        bias_wr_en    = 1'b0;
        bias_wr_addr  = 6'h0;
        bias_wr_data  = 16'h0;
        bus.acc_valid = 1'b0;
        bus.acc_in    = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_state");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Tile 1: directed columns 0..6, random bias elsewhere; last write shares the start cycle
        for (int c = 0; c < 64; c++) bias_model[c] = 16'($urandom);
        bias_model[0] = 16'h0400;
        bias_model[1] = 16'h0000;
        bias_model[2] = 16'h7FFF;
        bias_model[3] = 16'h8000;
        bias_model[4] = 16'h0000;
        bias_model[5] = 16'h0000;
        bias_model[6] = 16'h0000;
        for (int c = 0; c < 63; c++) write_bias(c, bias_model[c], 1'b0);
        write_bias(63, bias_model[63], 1'b1);
        d0 = done_cnt;
        a0 = acc_cnt;

        send(32'h0010_0000, '{d: 16'h0800, s: 1'b0, l: 1'b0}, "basic_path");
        @(negedge clk);
        chk("latency_cycle1", {63'h0, bus.out_valid}, 64'd0);
        @(negedge clk);
        chk("latency_cycle2", {63'h0, bus.out_valid}, 64'd1);
        @(posedge clk);
        #1;
        send(32'h0000_0200, '{d: 16'h0001, s: 1'b0, l: 1'b0}, "round_up_half");
        send(32'h7FFF_FFFF, '{d: 16'h7FFF, s: 1'b1, l: 1'b0}, "sat_pos");
        send(32'h8000_0000, '{d: 16'h8000, s: 1'b1, l: 1'b0}, "sat_neg");
        send(32'h0000_01FF, '{d: 16'h0000, s: 1'b0, l: 1'b0}, "round_below_half");
        send(32'hFFFF_FE00, '{d: 16'h0000, s: 1'b0, l: 1'b0}, "round_neg_half");
        send(32'hFFFF_FDFF, '{d: 16'hFFFF, s: 1'b0, l: 1'b0}, "round_neg_below");

        ready_mode = 1;
        for (int i = 7; i < 4096; i++) begin
            col = i % 64;
            if (i == 300) begin
                write_bias(0, 16'h1234, 1'b1);
            end
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            acc = $urandom;
            if (i % 97 == 0) acc = 32'h7FFF_FFFF;
            if (i % 89 == 0) acc = 32'h8000_0000;
            send(acc, model(acc, bias_model[col], col == 63), "tile1");
        end
        bus.acc_valid = 1'b1;
        bus.acc_in    = 32'h0;
        repeat (3) begin
            @(negedge clk);
            chk("acc_ready_after_tile", {63'h0, bus.acc_ready}, 64'd0);
        end
        @(posedge clk);
        #1;
        bus.acc_valid = 1'b0;
        wait_done(d0, a0);
        ready_mode = 0;

        // Tile 2: bias[0] must still hold 0x0400; then reset with data in flight
        repeat (2) @(posedge clk);
        #1;
        pulse_start();
        send(32'h0000_0000, '{d: 16'h0400, s: 1'b0, l: 1'b0}, "bias_write_ignored");
        send(32'h0000_0200, '{d: 16'h0001, s: 1'b0, l: 1'b0}, "tile2_col1");
        repeat (4) @(posedge clk);
        #1;
        ready_mode = 2;
        @(posedge clk);
        #1;
        acc = 32'h0012_3456;
        send(acc, model(acc, bias_model[2], 1'b0), "tile2_col2");
        repeat (3) @(posedge clk);
        #1;
        d0  = done_cnt;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_mid_tile");
        exp_q.delete();
        name_q.delete();
        ready_mode = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("no_done_after_reset", 64'(done_cnt - d0), 64'd0);

        // Tile 3: restarts from column 0 with the bias table intact
        @(posedge clk);
        #1;
        d0 = done_cnt;
        a0 = acc_cnt;
        pulse_start();
        send(32'h0000_0000, '{d: 16'h0400, s: 1'b0, l: 1'b0}, "col0_after_reset");
        for (int i = 1; i < 4096; i++) begin
            col = i % 64;
            acc = $urandom;
            send(acc, model(acc, bias_model[col], col == 63), "tile3");
        end
        wait_done(d0, a0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
